// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg - parametrised UART receiver with a valid/ready holding register.
//
// Configure the receiver through these parameters:
//   CLKS_PER_BIT - clk cycles per bit; must be >= 8.
//   DATA_BITS    - data bits per frame, 5..9, LSB first.
//   PARITY       - 0 = none, 1 = even, 2 = odd.
//   STOP_BITS    - 1 or 2.
//
// Ports:
//   clk, rst_n              - rising-edge clock; synchronous active-low reset.
//   rx                      - serial line (idle high).
//   rx_data, rx_valid       - received word and its valid flag.
//   rx_ready                - consumer handshake.
//   parity_err, frame_err   - error flags for the held word; qualified by rx_valid.
//   overrun, overrun_clr    - sticky overrun flag and its clear pulse.
//   busy, rx_state          - FSM status (debug).
//
// Optional feature:
//   UART_RX_MAJORITY_EN - when defined, each bit is the 2-of-3 majority of rx
//   sampled at centre-1, centre and centre+1. The decision is taken at
//   centre+1, so every sample point, and delivery, moves one cycle later.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 busy,
  output logic [2:0]           rx_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_WAIT   = 3'd5
  } state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt;
  logic [3:0]             bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_pend, frm_pend, deliver;
  logic                   samp, tick, last_stop;

`ifdef UART_RX_MAJORITY_EN
  // Centre-1 and centre values trail rx. Combined with rx itself (centre+1),
  // they form the vote at the decision edge.
  localparam logic [CW-1:0] START_END = CW'(CLKS_PER_BIT / 2);
  logic rx_d1, rx_d2;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_d1 <= rx;
      rx_d2 <= rx_d1;
    end
  end
  assign samp = (rx & rx_d1) | (rx & rx_d2) | (rx_d1 & rx_d2);
`else
  localparam logic [CW-1:0] START_END = CW'(CLKS_PER_BIT / 2 - 1);
  assign samp = rx;
`endif

  // The start check happens at mid start-bit. Every later tick is one full
  // bit period after the previous one, so samples land on bit centres.
  assign tick      = (state == S_START) ? (cnt == START_END) : (cnt == BIT_END);
  assign last_stop = (state == S_STOP) && tick && (bit_idx == STOP_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!rx) state_nxt = S_START;
      S_START:  if (tick) state_nxt = samp ? S_IDLE : S_DATA;
      S_DATA:   if (tick && bit_idx == DATA_LAST)
                  state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_nxt = S_STOP;
      // A low stop bit may be a break. Park until the line returns high, so a
      // held-low line produces only one errored word.
      S_STOP:   if (last_stop) state_nxt = (frm_pend || !samp) ? S_WAIT : S_IDLE;
      S_WAIT:   if (rx) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs derived from the state.
  always_comb begin
    busy     = (state != S_IDLE);
    rx_state = state;
  end

  // Bit timing, shift register and pending error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_pend <= 1'b0;
      frm_pend <= 1'b0;
      deliver  <= 1'b0;
    end else begin
      deliver <= last_stop;
      if (state == S_IDLE || state == S_WAIT || tick) cnt <= '0;
      else                                            cnt <= cnt + CW'(1);
      if (state_nxt != state)                            bit_idx <= '0;
      else if (tick && (state == S_DATA || state == S_STOP)) bit_idx <= bit_idx + 4'd1;
      if (state == S_START && tick) begin
        par_pend <= 1'b0;
        frm_pend <= 1'b0;
      end
      if (state == S_DATA && tick)   shreg <= {samp, shreg[DATA_BITS-1:1]};
      // Even parity: the bit should equal XOR(data). Odd parity: it should
      // equal the inverse of XOR(data).
      if (state == S_PARITY && tick) par_pend <= samp ^ (^shreg) ^ (PARITY == 2);
      if (state == S_STOP && tick && !samp) frm_pend <= 1'b1;
    end
  end

  // Holding register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data    <= shreg;
        parity_err <= par_pend;
        frame_err  <= frm_pend;
        rx_valid   <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (deliver && rx_valid && !rx_ready) overrun <= 1'b1;
      else if (overrun_clr)                 overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
module tb_uart_rx_cfg;
  localparam int C = 434;

  logic clk = 1'b0;
  logic rst_n, rx, rx_ready, overrun_clr;
  logic [7:0] rx_data;
  logic rx_valid, parity_err, frame_err, overrun, busy;
  logic [2:0] rx_state;

  logic rx_p, overrun_clr_p;
  logic [7:0] rx_data_p;
  logic rx_valid_p, parity_err_p, frame_err_p, overrun_p, busy_p;
  logic [2:0] rx_state_p;

  int n_chk = 0, n_err = 0;
  int cyc = 0, t0 = 0, base = 0;
  int nw = 0, rise = 0, npw = 0, prise = 0;
  logic [7:0] wd, pwd;
  logic wpe, wfe, pwpe, pwfe;
  logic v_q = 1'b0, pv_q = 1'b0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .overrun_clr(overrun_clr), .busy(busy), .rx_state(rx_state));

  uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut_p (
    .clk(clk), .rst_n(rst_n), .rx(rx_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p),
    .rx_ready(1'b1), .parity_err(parity_err_p), .frame_err(frame_err_p),
    .overrun(overrun_p), .overrun_clr(overrun_clr_p), .busy(busy_p), .rx_state(rx_state_p));

  // Transfer monitor: counts accepted words and records when valid rises.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      nw = nw + 1; wd = rx_data; wpe = parity_err; wfe = frame_err;
    end
    if (rx_valid && !v_q) rise = cyc;
    v_q = rx_valid;
    if (rx_valid_p) begin
      npw = npw + 1; pwd = rx_data_p; pwpe = parity_err_p; pwfe = frame_err_p;
    end
    if (rx_valid_p && !pv_q) prise = cyc;
    pv_q = rx_valid_p;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive n bits of frm LSB first, one bit period each, on rx (p=0) or rx_p (p=1).
  task automatic send(input logic [11:0] frm, input int n, input bit p);
    for (int i = 0; i < n; i++) begin
      if (i == 0) t0 = cyc;
      if (p) rx_p = frm[i];
      else   rx   = frm[i];
      repeat (C) @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [11:0] f8(input logic [7:0] d);
    return {3'b111, d, 1'b0};
  endfunction

  function automatic logic [11:0] fp(input logic [7:0] d, input logic par);
    return {2'b11, par, d, 1'b0};
  endfunction

  initial begin
    rst_n = 1'b0; rx = 1'b1; rx_p = 1'b1; rx_ready = 1'b1;
    overrun_clr = 1'b0; overrun_clr_p = 1'b0;
    wait_cyc(3);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", rx_state, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_pe", parity_err, 0);
    rst_n = 1'b1;
    wait_cyc(5);

    // 1: 8N1 word 0x47
    base = nw;
    send(f8(8'h47), 10, 1'b0);
    wait_cyc(10);
    chk("t1_words", nw - base, 1);
    chk("t1_data", wd, 8'h47);
    chk("t1_pe", wpe, 0);
    chk("t1_fe", wfe, 0);
    chk("t1_lat", rise - t0, C/2 + 9*C + 2);
    chk("t1_state", rx_state, 0);
    chk("t1_ovr", overrun, 0);

    // 2: even parity, 0xA5 has four ones so the correct parity bit is 0
    base = npw;
    send(fp(8'hA5, 1'b1), 11, 1'b1);
    wait_cyc(10);
    chk("t2_data", pwd, 8'hA5);
    chk("t2_pe_bad", pwpe, 1);
    chk("t2_fe", pwfe, 0);
    chk("t2_lat", prise - t0, C/2 + 10*C + 2);
    send(fp(8'hA5, 1'b0), 11, 1'b1);
    wait_cyc(10);
    chk("t2_pe_good", pwpe, 0);
    chk("t2_words", npw - base, 2);

    // 3: stop bit low, then a break held for 20 bit periods
    base = nw;
    send({3'b110, 8'h3C, 1'b0}, 10, 1'b0);
    wait_cyc(10*C);
    chk("t3_state_wait", rx_state, 5);
    chk("t3_busy", busy, 1);
    chk("t3_words", nw - base, 1);
    chk("t3_data", wd, 8'h3C);
    chk("t3_fe", wfe, 1);
    wait_cyc(10*C);
    rx = 1'b1;
    wait_cyc(3);
    chk("t3_state_idle", rx_state, 0);
    wait_cyc(2*C);
    chk("t3_no_second", nw - base, 1);

    // 4: overrun with consumer stalled
    rx_ready = 1'b0;
    send(f8(8'h11), 10, 1'b0);
    send(f8(8'h22), 10, 1'b0);
    wait_cyc(10);
    chk("t4_valid", rx_valid, 1);
    chk("t4_data", rx_data, 8'h11);
    chk("t4_ovr", overrun, 1);
    overrun_clr = 1'b1;
    wait_cyc(1);
    overrun_clr = 1'b0;
    chk("t4_ovr_clr", overrun, 0);
    chk("t4_hold", rx_data, 8'h11);
    rx_ready = 1'b1;
    wait_cyc(1);
    chk("t4_consumed", rx_valid, 0);
    chk("t4_data_kept", rx_data, 8'h11);

    // 5: short low glitch is a false start
    base = nw;
    rx = 1'b0;
    wait_cyc(100);
    chk("t5_start", rx_state, 1);
    rx = 1'b1;
    wait_cyc(200);
    chk("t5_idle", rx_state, 0);
    chk("t5_nobusy", busy, 0);
    chk("t5_words", nw - base, 0);
    chk("t5_valid", rx_valid, 0);

    // 6: reset during the 4th data bit of 0x55 with a word held
    rx_ready = 1'b0;
    send(f8(8'hC3), 10, 1'b0);
    wait_cyc(5);
    chk("t6_held", rx_data, 8'hC3);
    send(f8(8'h55), 4, 1'b0);
    rx = 1'b0;
    wait_cyc(C/2);
    chk("t6_mid_data", rx_state, 2);
    rst_n = 1'b0;
    wait_cyc(1);
    chk("t6_rst_valid", rx_valid, 0);
    chk("t6_rst_data", rx_data, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_state", rx_state, 0);
    rst_n = 1'b1; rx = 1'b1; rx_ready = 1'b1;
    wait_cyc(C);
    base = nw;
    send(f8(8'h96), 10, 1'b0);
    wait_cyc(10);
    chk("t6_words", nw - base, 1);
    chk("t6_data", wd, 8'h96);
    chk("t6_fe", wfe, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
